// File: rtl/mp_addsub_seq_if.sv
// Start/operand/result bundle for the multi-precision add/subtract sequencer.
// The master drives the request; the slave (sequencer) returns status and result.
interface mp_addsub_seq_if #(parameter int WORDS = 4);
   localparam int W = 32 * WORDS;

   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;

   modport master (output start, sub, a, b,
                   input  busy, done, result, cout, overflow);
   modport slave  (input  start, sub, a, b,
                   output busy, done, result, cout, overflow);
endinterface

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract: one shared 32-bit Brent-Kung adder walks the
// limbs LSB first, with the carry chained through a register between limbs.
module bentkung (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   output logic [31:0] sum_o,
   output logic        cout_o
);
   logic [31:0] gen;
   logic [31:0] prop;
   logic [31:0] grpGen;
   logic [31:0] grpProp;

   // Folding cin into bit 0's generate makes grpGen[i] the carry out of bit i.
   always_comb begin
      gen     = a_i & b_i;
      prop    = a_i ^ b_i;
      grpGen  = gen;
      grpProp = prop;
      grpGen[0] = gen[0] | (prop[0] & cin_i);
      for (int d = 0; d < 5; d++) begin
         for (int i = (2 << d) - 1; i < 32; i += (2 << d)) begin
            grpGen[i]  = grpGen[i] | (grpProp[i] & grpGen[i - (1 << d)]);
            grpProp[i] = grpProp[i] & grpProp[i - (1 << d)];
         end
      end
      for (int d = 3; d >= 0; d--) begin
         for (int i = (3 << d) - 1; i < 32; i += (2 << d)) begin
            grpGen[i]  = grpGen[i] | (grpProp[i] & grpGen[i - (1 << d)]);
            grpProp[i] = grpProp[i] & grpProp[i - (1 << d)];
         end
      end
      sum_o  = prop ^ {grpGen[30:0], cin_i};
      cout_o = grpGen[31];
   end
endmodule

module mp_addsub_seq #(parameter int WORDS = 4) (
   input logic           clk,
   input logic           rst_n,
   mp_addsub_seq_if.slave bus
);
   localparam int W  = 32 * WORDS;
   localparam int IW = $clog2(WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   logic [1:0]    state_q,  state_d;
   logic [IW-1:0] idx_q,    idx_d;
   logic          carry_q,  carry_d;
   logic [W-1:0]  aReg_q,   aReg_d;
   logic [W-1:0]  bReg_q,   bReg_d;
   logic [W-1:0]  result_q, result_d;
   logic          cout_q,   cout_d;
   logic          ovf_q,    ovf_d;

   logic [31:0] aLimb;
   logic [31:0] bLimb;
   logic [31:0] limbSum;
   logic        limbCout;

   assign aLimb = aReg_q[idx_q*32 +: 32];
   assign bLimb = bReg_q[idx_q*32 +: 32];

   bentkung adder (
      .a_i    (aLimb),
      .b_i    (bLimb),
      .cin_i  (carry_q),
      .sum_o  (limbSum),
      .cout_o (limbCout)
   );

   // Subtract is stored as a + ~b + 1: B is inverted at capture and the +1 seeds the carry.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      aReg_d   = aReg_q;
      bReg_d   = bReg_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               aReg_d  = bus.a;
               bReg_d  = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            result_d[idx_q*32 +: 32] = limbSum;
            carry_d = limbCout;
            if (idx_q == LAST_IDX) begin
               cout_d  = limbCout;
               ovf_d   = (aLimb[31] == bLimb[31]) && (limbSum[31] != aLimb[31]);
               state_d = FIN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         aReg_q   <= '0;
         bReg_q   <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         aReg_q   <= aReg_d;
         bReg_q   <= bReg_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == FIN);
   assign bus.result   = result_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_mp_addsub_seq.sv
// Self-checking bench for mp_addsub_seq: directed vectors with literal answers
// plus an arithmetic reference model compared against the DUT every cycle.
module tb_mp_addsub_seq;
   localparam int WORDS = 4;
   localparam int W     = 32 * WORDS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   mp_addsub_seq_if #(.WORDS(WORDS)) bus();

   mp_addsub_seq #(.WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference arithmetic straight from the a +/- b definition, no limb structure.
   function automatic logic [W-1:0] refResult(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      return s ? (x - y) : (x + y);
   endfunction

   function automatic logic refCout(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      logic [W:0] wide;
      if (s) return (x >= y);
      wide = {1'b0, x} + {1'b0, y};
      return wide[W];
   endfunction

   function automatic logic refOvf(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      logic signed [W:0] exact;
      if (s) exact = $signed({x[W-1], x}) - $signed({y[W-1], y});
      else   exact = $signed({x[W-1], x}) + $signed({y[W-1], y});
      return exact[W] != exact[W-1];
   endfunction

   int           mPhase;
   logic [W-1:0] mResult, pendResult;
   logic         mCout, mOvf, pendCout, pendOvf;

   // Model timeline: phase 1..WORDS are busy limb cycles, WORDS+1 is the done cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mPhase  <= 0;
         mResult <= '0;
         mCout   <= 1'b0;
         mOvf    <= 1'b0;
      end else if (mPhase == 0) begin
         if (bus.start) begin
            mPhase     <= 1;
            pendResult <= refResult(bus.a, bus.b, bus.sub);
            pendCout   <= refCout(bus.a, bus.b, bus.sub);
            pendOvf    <= refOvf(bus.a, bus.b, bus.sub);
         end
      end else if (mPhase == WORDS) begin
         mPhase  <= WORDS + 1;
         mResult <= pendResult;
         mCout   <= pendCout;
         mOvf    <= pendOvf;
      end else if (mPhase == WORDS + 1) begin
         mPhase <= 0;
      end else begin
         mPhase <= mPhase + 1;
      end
   end

   // Result is only defined once done rises and while it is held afterwards.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("cyc_busy", W'(bus.busy), W'(mPhase != 0));
         checkOutput("cyc_done", W'(bus.done), W'(mPhase == WORDS + 1));
         checkOutput("cyc_cout", W'(bus.cout), W'(mCout));
         checkOutput("cyc_overflow", W'(bus.overflow), W'(mOvf));
         if (mPhase == 0 || mPhase == WORDS + 1)
            checkOutput("cyc_result", bus.result, mResult);
      end
   end

   task automatic applyStimulus(input logic [W-1:0] aIn, input logic [W-1:0] bIn, input logic subIn);
      int guard = 0;
      while (bus.busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (bus.busy) begin
         checks++;
         failures++;
         $display("[TB] FAIL idle_wait: got busy=1 required busy=0 within 50 cycles");
      end
      bus.start = 1'b1;
      bus.sub   = subIn;
      bus.a     = aIn;
      bus.b     = bIn;
      @(negedge clk);
      bus.start = 1'b0;
      bus.sub   = ~subIn;
      bus.a     = {$urandom, $urandom, $urandom, $urandom};
      bus.b     = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic waitDone(output int cyc, output int busyCyc);
      cyc     = 2;
      busyCyc = 0;
      while (!bus.done && cyc < 60) begin
         if (bus.busy) busyCyc++;
         @(negedge clk);
         cyc++;
      end
      if (bus.busy) busyCyc++;
      if (!bus.done) begin
         checks++;
         failures++;
         $display("[TB] FAIL done_timeout: got done=0 required done=1 within 60 cycles");
      end
   endtask

   task automatic runOp(input string name, input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                        input logic subIn, input logic [W-1:0] expRes, input logic expCout, input logic expOvf);
      int cyc, busyCyc;
      applyStimulus(aIn, bIn, subIn);
      waitDone(cyc, busyCyc);
      checkOutput({name, "_result"}, bus.result, expRes);
      checkOutput({name, "_cout"}, W'(bus.cout), W'(expCout));
      checkOutput({name, "_overflow"}, W'(bus.overflow), W'(expOvf));
      checkOutput({name, "_latency"}, W'(cyc), W'(6));
      checkOutput({name, "_busycycles"}, W'(busyCyc), W'(5));
   endtask

   initial begin
      int doneCount;
      int cyc, busyCyc;
      logic [W-1:0] ra, rb;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      repeat (2) @(negedge clk);
      checkOutput("reset_busy", W'(bus.busy), '0);
      checkOutput("reset_done", W'(bus.done), '0);
      checkOutput("reset_result", bus.result, '0);
      checkOutput("reset_cout", W'(bus.cout), '0);
      checkOutput("reset_overflow", W'(bus.overflow), '0);
      rst_n = 1'b1;
      @(negedge clk);

      runOp("allones_plus1", {W{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0);
      runOp("borrow_chain", 128'h0000_0001_0000_0000_0000_0000_0000_0000, 128'd1, 1'b1,
            128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
      runOp("maxsigned_plus1", 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
            128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1);
      runOp("five_minus_seven", 128'd5, 128'd7, 1'b1,
            128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      runOp("equal_sub", 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
            128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 1'b1, 128'd0, 1'b1, 1'b0);

      // Extra starts in cycles 2 and 3 of a running op must be dropped.
      applyStimulus(128'd10, 128'd20, 1'b0);
      bus.start = 1'b1;
      bus.a     = 128'd99;
      bus.b     = 128'd99;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      doneCount = 0;
      repeat (12) begin
         if (bus.done) doneCount++;
         @(negedge clk);
      end
      checkOutput("ignored_start_result", bus.result, 128'd30);
      checkOutput("ignored_start_donecount", W'(doneCount), W'(1));

      // Reset while limb 2 is in flight.
      applyStimulus(128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 128'd77, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", W'(bus.busy), '0);
      checkOutput("midreset_done", W'(bus.done), '0);
      checkOutput("midreset_result", bus.result, '0);
      checkOutput("midreset_cout", W'(bus.cout), '0);
      checkOutput("midreset_overflow", W'(bus.overflow), '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      runOp("after_reset", 128'd3, 128'd4, 1'b0, 128'd7, 1'b0, 1'b0);

      for (int n = 0; n < 1500; n++) begin
         ra = {$urandom, $urandom, $urandom, $urandom};
         rb = {$urandom, $urandom, $urandom, $urandom};
         case ($urandom_range(0, 7))
            0: ra = {W{1'b1}};
            1: rb = ra;
            2: rb = '0;
            3: rb = {W{1'b1}};
            default: ;
         endcase
         applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
         waitDone(cyc, busyCyc);
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
